// File: rtl/dii_buffer_pkg.sv
// Shared helpers for DII buffering blocks: count-width derivation and the
// head-of-buffer packet length scan.
package dii_buffer_pkg;

   localparam int MAX_DEPTH = 64;
   localparam int IDX_W     = $clog2(MAX_DEPTH);

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Length of the packet at the head: flits from rd_ptr up to and including
   // the first stored last flag; 0 when no complete packet is stored.
   function automatic int head_packet_size(input logic [MAX_DEPTH-1:0] last_vec,
                                           input int rd_ptr,
                                           input int fill,
                                           input int depth);
      int               size;
      logic [IDX_W-1:0] idx;
      size = 0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         idx = IDX_W'((rd_ptr + i) & (depth - 1));
         if (size == 0 && i < fill && last_vec[idx]) begin
            size = i + 1;
         end
      end
      return size;
   endfunction

endpackage

// File: rtl/dii_channel.sv
// DII flit channel: data with first/last framing and a valid/ready handshake.
interface dii_channel #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data;
   logic             first;
   logic             last;
   logic             valid;
   logic             ready;

   modport master (output data, output first, output last, output valid, input ready);
   modport slave  (input data, input first, input last, input valid, output ready);
endinterface

// File: rtl/dii_packet_fifo_mem.sv
// Flit storage for dii_packet_fifo: one write port, combinational read, and
// a flat view of every entry's last flag for the packet-size scan.
module dii_packet_fifo_mem #(
   parameter int W     = 18,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [W-1:0]     wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [W-1:0]     rd_data,
   output logic [DEPTH-1:0] last_vec
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Entries carry no reset: contents are only meaningful behind the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = mem_q[rd_addr];
      for (int i = 0; i < DEPTH; i++) begin
         last_vec[i] = mem_q[i][W-2];
      end
   end

endmodule

// File: rtl/dii_packet_fifo.sv
// Pointer-based DII flit FIFO with occupancy/packet status, optional
// store-and-forward presentation and a starvation release for oversize packets.
module dii_packet_fifo
   import dii_buffer_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int FULLPACKET = 0,
   parameter int CW         = count_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   dii_channel.slave     in,
   dii_channel.master    out,
   output logic [CW-1:0] fill_level,
   output logic [CW-1:0] packet_count,
   output logic [CW-1:0] packet_size,
   output logic          starved
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            EW       = WIDTH + 2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fill_q, fill_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          release_q, release_d;

   logic          full, empty;
   logic          in_ready, out_valid;
   logic          push, pop;
   logic          pkt_inc, pkt_dec;
   logic [EW-1:0] wr_entry, rd_entry;
   logic [DEPTH-1:0] last_vec;

   assign wr_entry = {in.first, in.last, in.data};

   dii_packet_fifo_mem #(
      .W     (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk      (clk),
      .wr_en    (push),
      .wr_addr  (wr_ptr_q),
      .wr_data  (wr_entry),
      .rd_addr  (rd_ptr_q),
      .rd_data  (rd_entry),
      .last_vec (last_vec)
   );

   always_comb begin
      full     = (fill_q == FULL_CNT);
      empty    = (fill_q == '0);
      // Ready looks only at stored occupancy, so a same-cycle pop never makes room.
      in_ready = ~rst & ~full;
      if (FULLPACKET != 0) begin
         out_valid = (pkt_cnt_q != '0) | release_q;
      end else begin
         out_valid = ~empty;
      end
      push    = in.valid & in_ready;
      pop     = out_valid & out.ready;
      pkt_inc = push & in.last;
      pkt_dec = pop & rd_entry[WIDTH];
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      fill_d    = fill_q;
      pkt_cnt_d = pkt_cnt_q;
      release_d = release_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push, pop})
         2'b10:   fill_d = fill_q + CW'(1);
         2'b01:   fill_d = fill_q - CW'(1);
         default: fill_d = fill_q;
      endcase

      case ({pkt_inc, pkt_dec})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      // A full buffer with no complete packet can never become presentable:
      // stream it out cut-through until the packet's last flit has left.
      if (FULLPACKET == 0) begin
         release_d = 1'b0;
      end else if (release_q && pkt_dec) begin
         release_d = 1'b0;
      end else if (full && pkt_cnt_q == '0) begin
         release_d = 1'b1;
      end

      if (rst) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         fill_d    = '0;
         pkt_cnt_d = '0;
         release_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      pkt_cnt_q <= pkt_cnt_d;
      release_q <= release_d;
   end

   assign in.ready     = in_ready;
   assign out.valid    = out_valid;
   assign out.data     = rd_entry[WIDTH-1:0];
   assign out.last     = rd_entry[WIDTH];
   assign out.first    = rd_entry[WIDTH+1];
   assign fill_level   = fill_q;
   assign packet_count = pkt_cnt_q;
   assign starved      = release_q;
   assign packet_size  = CW'(head_packet_size(MAX_DEPTH'(last_vec), int'(rd_ptr_q),
                                              int'(fill_q), DEPTH));

endmodule

// File: tb/tb_dii_packet_fifo.sv
// Scoreboard bench for dii_packet_fifo: three instances (8-deep cut-through,
// 4-deep cut-through, 4-deep store-and-forward) driven by directed vectors.
module tb_dii_packet_fifo;

   typedef logic [17:0] flit_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] in_data  [3];
   logic        in_first [3];
   logic        in_last  [3];
   logic        in_valid [3];
   logic        out_ready[3];
   logic        in_ready [3];
   logic        o_valid  [3];
   logic        o_first  [3];
   logic        o_last   [3];
   logic [15:0] o_data   [3];
   logic        starv    [3];
   logic [31:0] fill     [3];
   logic [31:0] pcnt     [3];
   logic [31:0] psize    [3];

   logic [3:0] fill_a, pc_a, ps_a;
   logic [2:0] fill_b, pc_b, ps_b, fill_c, pc_c, ps_c;
   logic       st_a, st_b, st_c;

   dii_channel #(.WIDTH(16)) ia ();
   dii_channel #(.WIDTH(16)) oa ();
   dii_channel #(.WIDTH(16)) ib ();
   dii_channel #(.WIDTH(16)) ob ();
   dii_channel #(.WIDTH(16)) ic ();
   dii_channel #(.WIDTH(16)) oc ();

   assign ia.data = in_data[0]; assign ia.first = in_first[0]; assign ia.last = in_last[0];
   assign ia.valid = in_valid[0]; assign in_ready[0] = ia.ready; assign oa.ready = out_ready[0];
   assign o_valid[0] = oa.valid; assign o_first[0] = oa.first; assign o_last[0] = oa.last;
   assign o_data[0] = oa.data;
   assign ib.data = in_data[1]; assign ib.first = in_first[1]; assign ib.last = in_last[1];
   assign ib.valid = in_valid[1]; assign in_ready[1] = ib.ready; assign ob.ready = out_ready[1];
   assign o_valid[1] = ob.valid; assign o_first[1] = ob.first; assign o_last[1] = ob.last;
   assign o_data[1] = ob.data;
   assign ic.data = in_data[2]; assign ic.first = in_first[2]; assign ic.last = in_last[2];
   assign ic.valid = in_valid[2]; assign in_ready[2] = ic.ready; assign oc.ready = out_ready[2];
   assign o_valid[2] = oc.valid; assign o_first[2] = oc.first; assign o_last[2] = oc.last;
   assign o_data[2] = oc.data;

   assign fill[0] = 32'(fill_a); assign pcnt[0] = 32'(pc_a); assign psize[0] = 32'(ps_a);
   assign fill[1] = 32'(fill_b); assign pcnt[1] = 32'(pc_b); assign psize[1] = 32'(ps_b);
   assign fill[2] = 32'(fill_c); assign pcnt[2] = 32'(pc_c); assign psize[2] = 32'(ps_c);
   assign starv[0] = st_a; assign starv[1] = st_b; assign starv[2] = st_c;

   dii_packet_fifo #(.WIDTH(16), .DEPTH(8), .FULLPACKET(0)) dut_a (
      .clk(clk), .rst(rst), .in(ia), .out(oa),
      .fill_level(fill_a), .packet_count(pc_a), .packet_size(ps_a), .starved(st_a));
   dii_packet_fifo #(.WIDTH(16), .DEPTH(4), .FULLPACKET(0)) dut_b (
      .clk(clk), .rst(rst), .in(ib), .out(ob),
      .fill_level(fill_b), .packet_count(pc_b), .packet_size(ps_b), .starved(st_b));
   dii_packet_fifo #(.WIDTH(16), .DEPTH(4), .FULLPACKET(1)) dut_c (
      .clk(clk), .rst(rst), .in(ic), .out(oc),
      .fill_level(fill_c), .packet_count(pc_c), .packet_size(ps_c), .starved(st_c));

   int    n_cmp = 0;
   int    n_bad = 0;
   int    max_fill_a = 0;
   bit    wrap_done;
   flit_t sb0[$];
   flit_t sb1[$];
   flit_t sb2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic sb_push(input int k, input flit_t f);
      case (k)
         0:       sb0.push_back(f);
         1:       sb1.push_back(f);
         default: sb2.push_back(f);
      endcase
   endtask

   task automatic sb_pop(input int k, output flit_t f, output bit ok);
      ok = 1'b1;
      f  = '0;
      case (k)
         0:       if (sb0.size() > 0) f = sb0.pop_front(); else ok = 1'b0;
         1:       if (sb1.size() > 0) f = sb1.pop_front(); else ok = 1'b0;
         default: if (sb2.size() > 0) f = sb2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   // Monitor: every handshake seen on an output must match the next expected flit.
   always @(negedge clk) begin
      if (!rst) begin
         if (fill[0] > max_fill_a) max_fill_a = fill[0];
         for (int k = 0; k < 3; k++) begin
            if (o_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
               flit_t act, exp;
               bit    ok;
               act = {o_first[k], o_last[k], o_data[k]};
               sb_pop(k, exp, ok);
               if (!ok) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL pop_dut%0d: unexpected flit 0x%0h, none expected", k, act);
               end else begin
                  check($sformatf("pop_dut%0d", k), 32'(act), 32'(exp));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [15:0] d, input bit f, input bit l);
      int n;
      n = 0;
      in_data[k]  = d;
      in_first[k] = f;
      in_last[k]  = l;
      in_valid[k] = 1'b1;
      while (in_ready[k] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (in_ready[k] !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL push_timeout_dut%0d: ready=%b after %0d cycles, required 1", k, in_ready[k], n);
         in_valid[k] = 1'b0;
         return;
      end
      sb_push(k, {f, l, d});
      tick();
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_empty(input int k, input int max_cycles);
      int n;
      n = 0;
      while (fill[k] != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check($sformatf("drain_fill_dut%0d", k), fill[k], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_data[k] = '0; in_first[k] = 1'b0; in_last[k] = 1'b0;
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      end
      rst = 1'b1;
      tick();
      tick();
      check1("ready_during_reset", in_ready[0], 1'b0);
      rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_fill_%0d", k), fill[k], 0);
         check($sformatf("rst_pcnt_%0d", k), pcnt[k], 0);
         check($sformatf("rst_psize_%0d", k), psize[k], 0);
         check1($sformatf("rst_valid_%0d", k), o_valid[k], 1'b0);
         check1($sformatf("rst_ready_%0d", k), in_ready[k], 1'b1);
         check1($sformatf("rst_starved_%0d", k), starv[k], 1'b0);
      end

      // Cut-through, 8 deep: visible the cycle after the first push.
      out_ready[0] = 1'b1;
      push(0, 16'h00A1, 1'b1, 1'b0);
      check1("ct_valid_after_first", o_valid[0], 1'b1);
      push(0, 16'h00A2, 1'b0, 1'b0);
      push(0, 16'h00A3, 1'b0, 1'b1);
      wait_empty(0, 20);
      check("ct_pcnt_end", pcnt[0], 0);

      // 4 deep full: a pop does not open space for a same-cycle push.
      push(1, 16'hB001, 1'b1, 1'b0);
      push(1, 16'hB002, 1'b0, 1'b0);
      push(1, 16'hB003, 1'b0, 1'b0);
      push(1, 16'hB004, 1'b0, 1'b1);
      check("full_fill", fill[1], 4);
      check1("full_ready", in_ready[1], 1'b0);
      check("full_pcnt", pcnt[1], 1);
      check("full_psize", psize[1], 4);
      in_data[1] = 16'hBEEF; in_first[1] = 1'b0; in_last[1] = 1'b0;
      in_valid[1] = 1'b1; out_ready[1] = 1'b1;
      check1("full_ready_with_pop", in_ready[1], 1'b0);
      tick();
      in_valid[1] = 1'b0; out_ready[1] = 1'b0;
      check("full_after_pushpop_fill", fill[1], 3);
      check("full_after_pushpop_psize", psize[1], 3);
      out_ready[1] = 1'b1;
      wait_empty(1, 20);
      check("full_pcnt_end", pcnt[1], 0);

      // Store-and-forward: nothing presented until the last flit is stored.
      out_ready[2] = 1'b0;
      push(2, 16'hC001, 1'b1, 1'b0);
      check1("sf_valid_partial", o_valid[2], 1'b0);
      push(2, 16'hC002, 1'b0, 1'b1);
      check1("sf_valid_complete", o_valid[2], 1'b1);
      check("sf_psize", psize[2], 2);
      check("sf_pcnt", pcnt[2], 1);
      push(2, 16'hC003, 1'b1, 1'b0);
      check1("sf_valid_hold", o_valid[2], 1'b1);
      check("sf_pcnt_2", pcnt[2], 1);
      check("sf_psize_2", psize[2], 2);
      check("sf_fill_2", fill[2], 3);
      out_ready[2] = 1'b1;
      push(2, 16'hC004, 1'b0, 1'b0);
      push(2, 16'hC005, 1'b0, 1'b1);
      wait_empty(2, 30);
      check("sf_pcnt_end", pcnt[2], 0);

      // Oversize packet: starvation release streams it out.
      out_ready[2] = 1'b0;
      push(2, 16'h5001, 1'b1, 1'b0);
      push(2, 16'h5002, 1'b0, 1'b0);
      push(2, 16'h5003, 1'b0, 1'b0);
      push(2, 16'h5004, 1'b0, 1'b0);
      check("starve_fill", fill[2], 4);
      check1("starve_not_yet", starv[2], 1'b0);
      check1("starve_valid_not_yet", o_valid[2], 1'b0);
      tick();
      check1("starve_set", starv[2], 1'b1);
      check1("starve_valid", o_valid[2], 1'b1);
      out_ready[2] = 1'b1;
      push(2, 16'h5005, 1'b0, 1'b0);
      push(2, 16'h5006, 1'b0, 1'b1);
      check1("starve_held", starv[2], 1'b1);
      wait_empty(2, 30);
      check1("starve_cleared", starv[2], 1'b0);
      check("starve_pcnt_end", pcnt[2], 0);

      // Wrap: 20 flits with random back-pressure.
      wrap_done = 1'b0;
      max_fill_a = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               push(0, 16'h0100 + 16'(i), (i % 5) == 0, (i % 5) == 4);
            end
            wrap_done = 1'b1;
         end
         begin
            while (!wrap_done) begin
               out_ready[0] = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      out_ready[0] = 1'b1;
      wait_empty(0, 40);
      check1("wrap_max_fill_le8", max_fill_a <= 8, 1'b1);
      check("wrap_sb_empty", sb0.size(), 0);

      // Reset mid-packet discards everything.
      out_ready[0] = 1'b0;
      push(0, 16'hD001, 1'b1, 1'b0);
      push(0, 16'hD002, 1'b0, 1'b1);
      push(0, 16'hD003, 1'b1, 1'b0);
      push(0, 16'hD004, 1'b0, 1'b0);
      push(0, 16'hD005, 1'b0, 1'b0);
      check("pre_rst_fill", fill[0], 5);
      check("pre_rst_pcnt", pcnt[0], 1);
      rst = 1'b1;
      tick();
      sb0.delete();
      check("rst_mid_fill", fill[0], 0);
      check("rst_mid_pcnt", pcnt[0], 0);
      check1("rst_mid_valid", o_valid[0], 1'b0);
      check1("rst_mid_ready", in_ready[0], 1'b0);
      rst = 1'b0;
      tick();
      check1("post_rst_ready", in_ready[0], 1'b1);
      check("post_rst_psize", psize[0], 0);

      check("end_sb1_empty", sb1.size(), 0);
      check("end_sb2_empty", sb2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
